// File: rtl/wav_stream_pkg.sv
// wav_stream_pkg: shared state encoding and gap-counter width for the stream checker
package wav_stream_pkg;
  localparam int GW = 4;
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} wav_stream_state_t;
endpackage

// File: rtl/wav_interface_str.sv
// wav_interface_str: valid/ready stream; src drives tvalid/tdata, drain drives tready
interface wav_interface_str #(parameter int DW = 8);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  modport src   (output tvalid, output tdata, input tready);
  modport drain (output tready, input tvalid, input tdata);
endinterface

// File: rtl/wav_sat_cnt.sv
// wav_sat_cnt: CW-bit counter with sync clear (priority) and increment that sticks at all-ones; ports clk, rst_n, i_clr, i_inc, o_cnt
module wav_sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/wav_stream_chk.sv
// wav_stream_chk: stream drain that applies gap backpressure and checks beats against an incrementing counter; ports clk, rst_n, str (drain), ctl_run, ctl_gap, sts_end, sts_err, sts_cnt, sts_err_cnt
module wav_stream_chk
  import wav_stream_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  wav_interface_str.drain     str,
  input  logic                ctl_run,
  input  logic [GW-1:0]       ctl_gap,
  output logic                sts_end,
  output logic                sts_err,
  output logic [CW-1:0]       sts_cnt,
  output logic [CW-1:0]       sts_err_cnt
);
  wav_stream_state_t r_state, w_nxt;
  logic [GW-1:0] r_gap;
  logic [DW-1:0] r_exp;
  logic          r_err;
  logic          w_trn, w_clr, w_bad, w_last;
  assign w_trn      = str.tvalid & str.tready;
  assign w_clr      = (r_state == IDLE) & ctl_run;
  assign w_bad      = w_trn & (str.tdata != r_exp);
  assign w_last     = &str.tdata;
  assign str.tready = r_state == RUN;
  assign sts_end    = r_state == DONE;
  assign sts_err    = r_err;
  // An all-ones beat ends the sequence even when ctl_run drops on the same edge
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: w_nxt = ctl_run ? RUN : IDLE;
      RUN:  w_nxt = (w_trn && w_last) ? DONE :
                    !ctl_run ? IDLE :
                    (w_trn && ctl_gap != '0) ? GAP : RUN;
      GAP:  w_nxt = !ctl_run ? IDLE : (r_gap == GW'(1)) ? RUN : GAP;
      DONE: w_nxt = ctl_run ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  // ctl_gap is captured only on entry to GAP so later changes cannot stretch a gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_gap <= '0;
    else if (r_state == RUN && w_nxt == GAP) r_gap <= ctl_gap;
    else if (r_state == GAP) r_gap <= r_gap - 1'b1;
  // Resync on every beat so a dropped beat costs exactly one error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_exp <= '0;
    else if (w_clr) r_exp <= '0;
    else if (w_trn) r_exp <= str.tdata + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if (w_clr) r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
  wav_sat_cnt #(.CW(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_trn), .o_cnt(sts_cnt)
  );
  wav_sat_cnt #(.CW(CW)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_bad), .o_cnt(sts_err_cnt)
  );
endmodule
